// File: rtl/testpattern_gen_pkg.sv
// Shared types and constants for the video test pattern generator:
// pattern selector encoding, NTSC/PAL active windows and the colour-bar table.
package n64adv_tp_pkg;

   typedef enum logic [1:0] {
      TP_CHECKER = 2'd0,
      TP_BARS    = 2'd1,
      TP_RAMP    = 2'd2,
      TP_XHATCH  = 2'd3
   } pattern_t;

   // Window bounds are exclusive on both ends
   localparam int NTSC_VSTART = 18;
   localparam int NTSC_VSTOP  = 248;
   localparam int NTSC_HSTART = 57;
   localparam int NTSC_HSTOP  = 378;
   localparam int PAL_VSTART  = 22;
   localparam int PAL_VSTOP   = 296;
   localparam int PAL_HSTART  = 62;
   localparam int PAL_HSTOP   = 383;

   localparam int BAR_W = 40;

   // {R,G,B} flags, index 0 = leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                          3'b010, 3'b011, 3'b110, 3'b111};

endpackage

// File: rtl/testpattern_gen_if.sv
// Video-side bundle of the test pattern generator: pixel enable, mode/pattern select,
// sync in and the registered {sync, R, G, B} word out. Source drives through master.
interface testpattern_gen_if #(
   parameter int SYNC_W  = 4,
   parameter int COLOR_W = 8
);
   logic                          nVDSYNC;
   logic                          vmode;
   logic [1:0]                    pattern_sel;
   logic [SYNC_W-1:0]             Sync_in;
   logic [SYNC_W+3*COLOR_W-1:0]   vdata_out;

   modport master (output nVDSYNC, vmode, pattern_sel, Sync_in, input vdata_out);
   modport slave  (input nVDSYNC, vmode, pattern_sel, Sync_in, output vdata_out);
endinterface

// File: rtl/testpattern_gen_colorbars.sv
// Maps a line-local x (0..319) to one of eight 40-pixel colour bars at COLOR_W per channel.
// Purely combinational; no handshake.
module tp_colorbars
   import n64adv_tp_pkg::*;
#(
   parameter int COLOR_W = 8
) (
   input  logic [8:0]           x,
   output logic [3*COLOR_W-1:0] rgb
);

   logic [2:0] bar;

   // Descending compare chain: the smallest bound that x sits below selects the bar
   always_comb begin
      bar = 3'd7;
      for (int i = 6; i >= 0; i--) begin
         if (x < 9'((i + 1) * BAR_W)) bar = 3'(i);
      end
   end

   assign rgb = {{COLOR_W{BAR_RGB[bar][2]}},
                 {COLOR_W{BAR_RGB[bar][1]}},
                 {COLOR_W{BAR_RGB[bar][0]}}};

endmodule

// File: rtl/testpattern_gen.sv
// Replaces pixel colour with checker/bars/ramp/crosshatch inside the NTSC/PAL window; TP_BORDER_EN adds a white frame.
// Colour and sync both emerge one enabled cycle later; nVDSYNC high freezes all state (no other backpressure).
module testpattern_gen
   import n64adv_tp_pkg::*;
#(
   parameter int COLOR_W = 8,
   parameter int SYNC_W  = 4,
   parameter int H_CNT_W = 10,
   parameter int V_CNT_W = 9
) (
   input  logic              VCLK,
   input  logic              nRST,
   testpattern_gen_if.slave  vid
);

   localparam int RGB_W = 3 * COLOR_W;

   logic [SYNC_W+RGB_W-1:0] vdata_q;
   logic [H_CNT_W-1:0]      hcnt;
   logic [V_CNT_W-1:0]      vcnt;
   pattern_t                pattern_q;

   logic [H_CNT_W-1:0] hstart, hstop;
   logic [V_CNT_W-1:0] vstart, vstop;
   logic               hsync_rise, vsync_rise, in_win, ck_bit;
   logic [8:0]         x;
   logic [4:0]         y_lo;
   logic [COLOR_W-1:0] ramp;
   logic [RGB_W-1:0]   bars_rgb, pix;

   assign hstart = vid.vmode ? H_CNT_W'(PAL_HSTART) : H_CNT_W'(NTSC_HSTART);
   assign hstop  = vid.vmode ? H_CNT_W'(PAL_HSTOP)  : H_CNT_W'(NTSC_HSTOP);
   assign vstart = vid.vmode ? V_CNT_W'(PAL_VSTART) : V_CNT_W'(NTSC_VSTART);
   assign vstop  = vid.vmode ? V_CNT_W'(PAL_VSTOP)  : V_CNT_W'(NTSC_VSTOP);

   // Edges are taken against the sync we last emitted, so no extra history register
   assign hsync_rise = vid.Sync_in[1] & ~vdata_q[RGB_W+1];
   assign vsync_rise = vid.Sync_in[3] & ~vdata_q[RGB_W+3];

   assign in_win = (vcnt > vstart) && (vcnt < vstop) && (hcnt > hstart) && (hcnt < hstop);
   assign x      = 9'(hcnt - hstart - H_CNT_W'(1));
   assign y_lo   = 5'(vcnt - vstart - V_CNT_W'(1));

   generate
      if (COLOR_W > 8) begin : g_ramp_pad
         assign ramp = {x[8:1], (COLOR_W-8)'(0)};
      end else begin : g_ramp_trunc
         assign ramp = x[8 -: COLOR_W];
      end
   endgenerate

   tp_colorbars #(.COLOR_W(COLOR_W)) u_colorbars (
      .x   (x),
      .rgb (bars_rgb)
   );

   always_comb begin
      pix    = '0;
      ck_bit = (hcnt == hstart + H_CNT_W'(1)) ? vcnt[0] : ~vdata_q[0];
      case (pattern_q)
         TP_CHECKER: pix = {RGB_W{ck_bit}};
         TP_BARS:    pix = bars_rgb;
         TP_RAMP:    pix = {3{ramp}};
         TP_XHATCH:  pix = {RGB_W{(x[4:0] == 5'd0) || (y_lo == 5'd0)}};
         default:    pix = '0;
      endcase
`ifdef TP_BORDER_EN
      if ((x == 9'd0) || (x == 9'd319) ||
          (vcnt == vstart + V_CNT_W'(1)) || (vcnt == vstop - V_CNT_W'(1)))
         pix = '1;
`endif
      if (!in_win) pix = '0;
   end

   // A V edge coinciding with an H edge wins on vcnt (later assignment)
   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         vdata_q   <= '0;
         hcnt      <= '0;
         vcnt      <= '0;
         pattern_q <= TP_CHECKER;
      end else if (!vid.nVDSYNC) begin
         vdata_q <= {vid.Sync_in, pix};
         if (hsync_rise) begin
            hcnt <= '0;
            if (vcnt != '1) vcnt <= vcnt + V_CNT_W'(1);
         end else if (hcnt != '1) begin
            hcnt <= hcnt + H_CNT_W'(1);
         end
         if (vsync_rise) begin
            vcnt      <= '0;
            pattern_q <= pattern_t'(vid.pattern_sel);
         end
      end
   end

   assign vid.vdata_out = vdata_q;

endmodule

// File: tb/tb_testpattern_gen.sv
// Scoreboard bench for testpattern_gen: synthetic lines push expected pixels, a monitor pops and compares.
module tb_testpattern_gen;

   localparam int SYNC_W  = 4;
   localparam int COLOR_W = 8;
   localparam int RGB_W   = 3 * COLOR_W;
   localparam int DW      = SYNC_W + RGB_W;

`ifdef TP_BORDER_EN
   localparam logic [RGB_W-1:0] BRD = 24'hFFFFFF;
`else
   localparam logic [RGB_W-1:0] BRD = 24'h000000;
`endif
   localparam logic [RGB_W-1:0] NBRD = ~BRD;
   localparam logic [RGB_W-1:0] WHT  = 24'hFFFFFF;
   localparam logic [RGB_W-1:0] BLK  = 24'h000000;

   logic VCLK = 1'b0;
   logic nRST;
   always #5 VCLK = ~VCLK;

   testpattern_gen_if #(.SYNC_W(SYNC_W), .COLOR_W(COLOR_W)) bus ();

   testpattern_gen #(.COLOR_W(COLOR_W), .SYNC_W(SYNC_W), .H_CNT_W(10), .V_CNT_W(9)) dut (
      .VCLK (VCLK),
      .nRST (nRST),
      .vid  (bus.slave)
   );

   typedef struct {
      int            cyc;
      logic [DW-1:0] exp;
      string         name;
   } exp_t;

   typedef struct {
      int               h;
      logic [RGB_W-1:0] rgb;
      string            name;
   } want_t;

   exp_t  sb[$];
   want_t wants[$];
   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: output is compared one cycle after the stimulus that produced it
   initial begin
      forever begin
         @(posedge VCLK);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc == cyc) begin
               check(e.name, 32'(bus.vdata_out), 32'(e.exp));
            end else begin
               errors++;
               $display("FAIL %s: stale entry for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
            end
         end
      end
   end

   task automatic tick(input logic [3:0] s, input logic en_n, input bit chk,
                       input logic [DW-1:0] e, input string name);
      @(negedge VCLK);
      bus.Sync_in = s;
      bus.nVDSYNC = en_n;
      if (chk) begin
         exp_t x;
         x.cyc  = cyc + 1;
         x.exp  = e;
         x.name = name;
         sb.push_back(x);
      end
      @(posedge VCLK);
      #1;
   endtask

   task automatic want(input int h, input logic [RGB_W-1:0] rgb, input string name);
      want_t w;
      w.h    = h;
      w.rgb  = rgb;
      w.name = name;
      wants.push_back(w);
   endtask

   // Line: cycle 0 drops nHSYNC (and nVSYNC if vs), cycle 1 raises them -> hcnt=0.
   // Cycle j>=2 therefore emits the pixel for hcnt=j-2.
   task automatic run_line(input int len, input bit vs, input int frz_at,
                           input logic [RGB_W-1:0] frz_rgb);
      for (int j = 0; j < len; j++) begin
         logic [3:0]       s;
         bit               chk;
         logic [RGB_W-1:0] rgb;
         string            nm;
         if (j == frz_at) begin
            for (int k = 0; k < 10; k++)
               tick(4'b1100, 1'b1, 1'b1, {4'hF, frz_rgb}, "freeze_hold");
            check("freeze_hcnt", 32'(dut.hcnt), 32'(frz_at - 2));
         end
         s   = (j == 0) ? (vs ? 4'b0100 : 4'b1100) : 4'b1111;
         chk = 1'b0;
         rgb = '0;
         nm  = "";
         foreach (wants[w]) begin
            if (wants[w].h == j - 2) begin
               chk = 1'b1;
               rgb = wants[w].rgb;
               nm  = wants[w].name;
            end
         end
         tick(s, 1'b0, chk, {s, rgb}, nm);
      end
      wants.delete();
   endtask

   task automatic short_lines(input int n);
      for (int i = 0; i < n; i++) run_line(4, 1'b0, -1, '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST            = 1'b0;
      bus.nVDSYNC     = 1'b0;
      bus.vmode       = 1'b0;
      bus.pattern_sel = 2'd3;
      bus.Sync_in     = 4'hF;
      repeat (3) @(posedge VCLK);
      @(negedge VCLK);
      nRST = 1'b1;

      // Mid-frame asynchronous reset
      want(100, BLK, "pre_reset_black");
      run_line(202, 1'b0, -1, '0);
      check("pre_reset_hcnt", 32'(dut.hcnt), 32'd200);
      check("pre_reset_pattern", 32'(dut.pattern_q), 32'd3);
      #2 nRST = 1'b0;
      #1;
      check("reset_vdata", 32'(bus.vdata_out), 32'd0);
      check("reset_hcnt", 32'(dut.hcnt), 32'd0);
      check("reset_vcnt", 32'(dut.vcnt), 32'd0);
      check("reset_pattern", 32'(dut.pattern_q), 32'd0);
      repeat (2) @(posedge VCLK);
      @(negedge VCLK);
      nRST = 1'b1;
      tick(4'hF, 1'b0, 1'b1, {4'hF, BLK}, "post_reset_black");

      // NTSC checker; also simultaneous H/V edges
      bus.pattern_sel = 2'd0;
      bus.vmode       = 1'b0;
      run_line(4, 1'b0, -1, '0);
      run_line(2, 1'b1, -1, '0);
      check("hv_edge_vcnt", 32'(dut.vcnt), 32'd0);
      check("hv_edge_hcnt", 32'(dut.hcnt), 32'd0);
      check("hv_edge_pattern", 32'(dut.pattern_q), 32'd0);
      short_lines(18);
      want(57,  BLK, "ck_h57_black");
      want(58,  WHT, "ck_v19_x0");
      want(59,  BRD, "ck_v19_x1");
      want(376, WHT, "ck_v19_x318");
      want(378, BLK, "ck_h378_black");
      run_line(390, 1'b0, -1, '0);
      want(58, BRD,  "ck_v20_x0");
      want(59, NBRD, "ck_v20_x1");
      run_line(390, 1'b0, -1, '0);

      // PAL colour bars
      bus.vmode       = 1'b1;
      bus.pattern_sel = 2'd1;
      run_line(2, 1'b1, -1, '0);
      short_lines(21);
      want(63, BLK, "bars_v22_black");
      run_line(390, 1'b0, -1, '0);
      want(62, BLK, "bars_h62_black");
      want(63, WHT, "bars_first_line");
      run_line(390, 1'b0, -1, '0);
      want(63,  WHT,          "bars_x0");
      want(102, WHT,          "bars_x39");
      want(103, 24'hFFFF00,   "bars_x40");
      want(342, 24'h0000FF,   "bars_x279");
      want(343, BLK,          "bars_x280");
      run_line(390, 1'b0, -1, '0);
      short_lines(76);
      bus.pattern_sel = 2'd2;
      short_lines(1);
      check("sel_ignored_mid", 32'(dut.pattern_q), 32'd1);
      want(63,  WHT,        "bars_hold_x0");
      want(103, 24'hFFFF00, "bars_hold_x40");
      run_line(390, 1'b0, -1, '0);
      short_lines(9);

      // Gray ramp after the next V edge, with a pixel-enable stall mid-line
      run_line(2, 1'b1, -1, '0);
      check("ramp_latched", 32'(dut.pattern_q), 32'd2);
      short_lines(23);
      want(63,  BRD,        "ramp_x0");
      want(65,  24'h010101, "ramp_x2");
      want(200, 24'h444444, "ramp_x137");
      want(201, 24'h454545, "ramp_x138_resume");
      want(381, 24'h9F9F9F, "ramp_x318");
      run_line(390, 1'b0, 203, 24'h444444);

      // NTSC crosshatch
      bus.vmode       = 1'b0;
      bus.pattern_sel = 2'd3;
      run_line(2, 1'b1, -1, '0);
      short_lines(18);
      want(57,  BLK, "xh_h57_black");
      want(58,  WHT, "xh_v19_x0");
      want(158, WHT, "xh_y0_x100");
      want(377, WHT, "xh_y0_x319");
      run_line(390, 1'b0, -1, '0);
      short_lines(4);
      want(58,  WHT, "xh_y5_x0");
      want(154, WHT, "xh_y5_x96");
      want(158, BLK, "xh_y5_x100");
      want(377, BRD, "xh_y5_x319");
      run_line(390, 1'b0, -1, '0);
      short_lines(222);
      want(158, BRD, "xh_ylast_x100");
      run_line(390, 1'b0, -1, '0);
      want(58, BLK, "xh_v248_outside");
      run_line(390, 1'b0, -1, '0);

      // Missing sync: counters saturate
      run_line(1100, 1'b0, -1, '0);
      check("hcnt_saturate", 32'(dut.hcnt), 32'd1023);
      short_lines(300);
      check("vcnt_saturate", 32'(dut.vcnt), 32'd511);

      repeat (3) @(posedge VCLK);
      #2;
      if (sb.size() != 0) begin
         errors += sb.size();
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/testpattern_gen.md
Name: testpattern_gen

Overview:
- Parametrised, multi-pattern successor to the single-checkerboard test pattern generator in the PPU video path.
- Sits between the sync source and the output mux; it replaces the pixel colour with one of four selectable patterns inside an NTSC/PAL active window.
- Sync is passed through with the same one-enabled-cycle latency as colour.

Parameters:
COLOR_W, 8, bits per colour channel (R, G, B)
SYNC_W, 4, sync bus width: [3]=nVSYNC, [2]=nCLAMP, [1]=nHSYNC, [0]=nCSYNC
H_CNT_W, 10, horizontal counter width
V_CNT_W, 9, vertical counter width

Ports:
VCLK  in  1  video clock; all state changes on its rising edge
nRST  in  1  asynchronous active-low reset
nVDSYNC  in  1  pixel enable; logic advances only when low
vmode  in  1  0 = NTSC window, 1 = PAL window
pattern_sel  in  2  0 checker, 1 colour bars, 2 gray ramp, 3 crosshatch
Sync_in  in  SYNC_W  incoming sync bits
vdata_out  out  SYNC_W+3*COLOR_W  {sync, R, G, B}; sync in the MSBs

Interface (already decided):
- One clock, VCLK.
- Reset nRST is asynchronous and active-low.

Behaviour:
- Reset:
  - vdata_out = 0; hcnt = 0; vcnt = 0; pattern_q = 0 (checker).
  - Asserting reset mid-frame clears everything immediately.
- nVDSYNC high: all registers hold.
- Edge detection compares Sync_in against the registered sync bits in vdata_out.
  - posedge nHSYNC: hcnt <= 0; vcnt <= vcnt+1, saturating at all-ones.
  - Otherwise hcnt <= hcnt+1, saturating at all-ones.
  - posedge nVSYNC: vcnt <= 0 and pattern_q <= pattern_sel. This overrides the vcnt increment when it coincides with an H edge.
  - pattern_sel changes mid-frame are ignored until the next V edge.
- Window, from package constants, with strict inequalities:
  - NTSC: 18 < vcnt < 248 and 57 < hcnt < 378.
  - PAL: 22 < vcnt < 296 and 62 < hcnt < 383.
  - Local coordinates: x = hcnt - hstart - 1 (0..319), y = vcnt - vstart - 1.
- Pattern definitions (all channels equal unless noted):
  - Checker: pixel = ~previous output bit 0. At x==0 (hcnt==hstart+1) the pixel is seeded with vcnt[0], so phase alternates per line.
  - Colour bars: 8 bars, 40 px each. Bar = x/40, computed via a compare chain with no divider. Order: white, yellow, cyan, green, magenta, red, blue, black. Full scale is all-ones per channel.
  - Gray ramp: g = top COLOR_W bits of x[8:1]. If COLOR_W > 8, zero-pad the LSBs.
  - Crosshatch: white when x[4:0]==0 or y[4:0]==0, else black.
- Outside the window, colour = 0.
- Latency: colour and sync both appear exactly one enabled cycle after their inputs/counters, so they stay aligned.
- Counter saturation: if sync is absent, counters stick at max, the output stays black, and sync still passes through.

Optional Feature:
- Macro: TP_BORDER_EN.
- Defined: pixels at x==0, x==319, y==0 and y==last active line are forced white, overriding the pattern.
- Undefined: no border logic is synthesised and the pattern is output unchanged.

Decomposition:
- Package n64adv_tp_pkg:
  - pattern_t enum (TP_CHECKER, TP_BARS, TP_RAMP, TP_XHATCH).
  - Window constants (VSTART/VSTOP/HSTART/HSTOP for NTSC and PAL).
  - Bar width constant of 40.
  - 8-entry bar colour table as 3-bit RGB flags.
- One sub-module, tp_colorbars: maps x to {R,G,B} at COLOR_W. Purely combinational; instantiated once.

Test Plan:
- Reset with nRST low mid-frame (hcnt=200), then release -> vdata_out==0, counters 0, first pixel after release is black.
- NTSC, pattern 0, 263 lines of synthetic sync -> on vcnt=19, x=0 colour = 1s (vcnt odd), x=1 = 0s; vcnt=20, x=0 = 0s; hcnt=57 and hcnt=378 black.
- Colour bars, PAL -> x=0 white, x=40 yellow (R=G=max, B=0), x=279 blue, x=280 black; the line after vcnt=22 is the first coloured line.
- pattern_sel 1→2 at mid-frame (vcnt=100) -> bars continue to end of frame; gray ramp starts after the next nVSYNC rising edge; ramp x=318 gives 8'd159.
- Simultaneous nHSYNC and nVSYNC rising edges -> vcnt=0, hcnt=0. Also: nVDSYNC held high 10 cycles -> outputs and counters frozen.
- Build with TP_BORDER_EN, crosshatch -> x=0 and x=319 white on every active line; x=100, y=5 black; x=96 white.
